// File: rtl/wb_gpio_in_pkg.sv
// -----------------------------------------------------------------------------
// wb_gpio_in_pkg
// Shared constants for the wb_gpio_in Wishbone GPIO input peripheral:
//   - register word indices (decoded from byte address bits [4:2])
//   - address decode width and position
//   - priming counter width
//   - sel_to_mask(): expands a 4-bit Wishbone byte select into a 32-bit mask
// -----------------------------------------------------------------------------
package wb_gpio_in_pkg;

   localparam int ADR_W   = 3;
   localparam int ADR_LSB = 2;

   localparam logic [ADR_W-1:0] GPIO_IN_DATA    = 3'd0;
   localparam logic [ADR_W-1:0] GPIO_IN_RISE_EN = 3'd1;
   localparam logic [ADR_W-1:0] GPIO_IN_FALL_EN = 3'd2;
   localparam logic [ADR_W-1:0] GPIO_IN_PENDING = 3'd3;
   localparam logic [ADR_W-1:0] GPIO_IN_MASK    = 3'd4;

   // Wide enough for SYNC_STAGES+1 with SYNC_STAGES up to 4.
   localparam int PRIME_CNT_W = 3;

   function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/wb_gpio_in_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// WIDTH x SYNC_STAGES flip-flop synchroniser chain for asynchronous inputs.
// All stages reset asynchronously to 0.
// Ports:
//   clk_i    destination clock
//   rst_i    asynchronous active-high reset
//   async_i  [WIDTH] asynchronous inputs
//   sync_o   [WIDTH] last stage of the chain
// -----------------------------------------------------------------------------
module gpio_sync #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] stage [SYNC_STAGES];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= async_i;
         for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign sync_o = stage[SYNC_STAGES-1];

endmodule

// File: rtl/wb_gpio_in.sv
// -----------------------------------------------------------------------------
// wb_gpio_in
// Wishbone B4 classic slave sampling external GPIO inputs. Inputs are
// synchronised into clk_i; with WB_GPIO_IN_IRQ_EN defined, rising/falling
// edges are latched into sticky PENDING bits and masked pending bits drive a
// registered level interrupt. Without WB_GPIO_IN_IRQ_EN only DATA exists and
// irq_o is tied 0.
// Register map (word index adr[4:2]):
//   0 DATA (RO), 1 RISE_EN, 2 FALL_EN, 3 PENDING (RW1C), 4 MASK, 5..7 read 0
// Ports:
//   clk_i, rst_i (async, active-high)
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[31:0], wb_dat_i[31:0], wb_sel_i[3:0]
//   wb_dat_o[31:0] registered read data, 0 when wb_ack_o is low
//   wb_ack_o       single-cycle acknowledge
//   gpio_i[WIDTH]  asynchronous inputs
//   irq_o          level interrupt
// -----------------------------------------------------------------------------
module wb_gpio_in
   import wb_gpio_in_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [31:0]      wb_adr_i,
   input  logic [31:0]      wb_dat_i,
   input  logic [3:0]       wb_sel_i,
   output logic [31:0]      wb_dat_o,
   output logic             wb_ack_o,
   input  logic [WIDTH-1:0] gpio_i,
   output logic             irq_o
);

   logic [WIDTH-1:0] sync;
   logic             req;
   logic             wr;
   logic [ADR_W-1:0] idx;
   logic [31:0]      rdata;

   gpio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (gpio_i),
      .sync_o  (sync)
   );

   // Gating with ~wb_ack_o limits the slave to one transfer every other cycle.
   assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr  = req & wb_we_i;
   assign idx = wb_adr_i[ADR_LSB +: ADR_W];

`ifdef WB_GPIO_IN_IRQ_EN
   localparam logic [PRIME_CNT_W-1:0] PRIME_DONE = PRIME_CNT_W'(SYNC_STAGES + 1);

   logic [WIDTH-1:0]       prev;
   logic [WIDTH-1:0]       rise_en;
   logic [WIDTH-1:0]       fall_en;
   logic [WIDTH-1:0]       pending;
   logic [WIDTH-1:0]       mask;
   logic [WIDTH-1:0]       rise;
   logic [WIDTH-1:0]       fall;
   logic [WIDTH-1:0]       clr;
   logic [WIDTH-1:0]       wmask;
   logic [31:0]            lane_mask;
   logic [PRIME_CNT_W-1:0] prime_cnt;
   logic                   primed;

   assign lane_mask = sel_to_mask(wb_sel_i);
   assign wmask     = lane_mask[WIDTH-1:0];

   // prev starts at 0 after reset, so an input held high would look like a
   // rising edge; detection stays off until the chain and prev have filled.
   assign primed = (prime_cnt == PRIME_DONE);
   assign rise   = primed ? (sync & ~prev & rise_en) : '0;
   assign fall   = primed ? (~sync & prev & fall_en) : '0;
   assign clr    = (wr && idx == GPIO_IN_PENDING) ? (wb_dat_i[WIDTH-1:0] & wmask) : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev      <= '0;
         rise_en   <= '0;
         fall_en   <= '0;
         pending   <= '0;
         mask      <= '0;
         prime_cnt <= '0;
         irq_o     <= 1'b0;
      end else begin
         prev <= sync;
         if (!primed) prime_cnt <= prime_cnt + 1'b1;
         if (wr && idx == GPIO_IN_RISE_EN)
            rise_en <= (rise_en & ~wmask) | (wb_dat_i[WIDTH-1:0] & wmask);
         if (wr && idx == GPIO_IN_FALL_EN)
            fall_en <= (fall_en & ~wmask) | (wb_dat_i[WIDTH-1:0] & wmask);
         if (wr && idx == GPIO_IN_MASK)
            mask <= (mask & ~wmask) | (wb_dat_i[WIDTH-1:0] & wmask);
         // A new edge in the same cycle as a clear keeps the bit set.
         pending <= (pending & ~clr) | rise | fall;
         irq_o   <= |(pending & mask);
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, wb_adr_i[31:ADR_LSB+ADR_W], wb_adr_i[ADR_LSB-1:0]};
`else
   assign irq_o = 1'b0;

   logic unused_ok;
   assign unused_ok = &{1'b0, wb_adr_i[31:ADR_LSB+ADR_W], wb_adr_i[ADR_LSB-1:0],
                        wb_dat_i, wb_sel_i, wr};
`endif

   always_comb begin
      rdata = '0;
      case (idx)
         GPIO_IN_DATA:    rdata[WIDTH-1:0] = sync;
`ifdef WB_GPIO_IN_IRQ_EN
         GPIO_IN_RISE_EN: rdata[WIDTH-1:0] = rise_en;
         GPIO_IN_FALL_EN: rdata[WIDTH-1:0] = fall_en;
         GPIO_IN_PENDING: rdata[WIDTH-1:0] = pending;
         GPIO_IN_MASK:    rdata[WIDTH-1:0] = mask;
`endif
         default:         rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= req;
         wb_dat_o <= req ? rdata : '0;
      end
   end

endmodule

// File: tb/tb_wb_gpio_in.sv
// -----------------------------------------------------------------------------
// tb_wb_gpio_in
// Self-checking bench for wb_gpio_in (WIDTH=32, SYNC_STAGES=2). Expected
// register values adapt to whether WB_GPIO_IN_IRQ_EN is defined. Reads push
// their expected data into a scoreboard queue; a monitor pops and compares on
// every acknowledge.
// -----------------------------------------------------------------------------
module tb_wb_gpio_in;

   localparam int SS = 2;
`ifdef WB_GPIO_IN_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, wdat = '0;
   logic [3:0]  sel = '0;
   logic [31:0] rdat;
   logic        ack;
   logic [31:0] gpio = 32'hFFFF_FFFF;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        chk;
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp_irq;
      logic [31:0] exp_min;
      string       name;
   } vec_t;
   vec_t vecs[$];

   wb_gpio_in #(.WIDTH(32), .SYNC_STAGES(SS)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_adr_i (adr),
      .wb_dat_i (wdat),
      .wb_sel_i (sel),
      .wb_dat_o (rdat),
      .wb_ack_o (ack),
      .gpio_i   (gpio),
      .irq_o    (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every acknowledge consumes one expected entry.
   always @(negedge clk) begin
      if (ack) begin
         if (sb_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            if (e.chk) check(e.name, rdat, e.exp);
         end
      end
   end

   // Stimulus phase: every task starts and ends 1 time unit after a rising edge.
   task automatic bus_drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic c, input logic [31:0] e,
                            input string name);
      sb_q.push_back('{c, e, name});
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
   endtask

   task automatic bus_complete(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ack && n < 8);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check({name, "_ack_latency"}, 32'(n), 32'd1);
      @(posedge clk); #1;
      check({name, "_ack_drop"}, {31'd0, ack}, 32'd0);
      check({name, "_dat_idle"}, rdat, 32'd0);
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input string name);
      bus_drive(1'b1, a, d, s, 1'b0, 32'd0, name);
      bus_complete(name);
   endtask

   task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string name);
      bus_drive(1'b0, a, 32'd0, 4'h0, 1'b1, e, name);
      bus_complete(name);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int acks;

      // Reset with all inputs high; RISE_EN write queued to land on the first edge.
      cycles(3);
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_dat", rdat, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      bus_drive(1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0, "prime_rise_en");
      rst = 1'b0;
      bus_complete("prime_rise_en");
      cycles(6);
      check("prime_irq", {31'd0, irq}, 32'd0);
      bus_rd(32'h0C, 32'd0, "prime_pending");
      bus_rd(32'h00, 32'hFFFF_FFFF, "prime_data");
      bus_rd(32'h04, IRQ ? 32'hFFFF_FFFF : 32'd0, "prime_rise_en_rd");

      // Rising edge on bit 0 through to interrupt and clear.
      gpio = 32'd0;
      cycles(6);
      bus_wr(32'h0C, 32'hFFFF_FFFF, 4'hF, "clr_all");
      bus_wr(32'h04, 32'h1, 4'hF, "rise_en_1");
      bus_wr(32'h10, 32'h1, 4'hF, "mask_1");
      check("irq_idle", {31'd0, irq}, 32'd0);
      gpio[0] = 1'b1;
      for (int i = 0; i <= SS + 1; i++) begin
         @(posedge clk); #1;
         check($sformatf("irq_edge%0d", i), {31'd0, irq},
               {31'd0, (IRQ && i == SS + 1)});
      end
      bus_rd(32'h0C, IRQ ? 32'h1 : 32'd0, "pending_rise");
      bus_rd(32'h00, 32'h1, "data_bit0");
      bus_wr(32'h0C, 32'h1, 4'hF, "clr_bit0");
      check("irq_cleared", {31'd0, irq}, 32'd0);
      bus_rd(32'h0C, 32'd0, "pending_cleared");

      // Falling edge on bit 7 coincides with a PENDING clear of bit 7.
      bus_wr(32'h08, 32'h80, 4'hF, "fall_en_80");
      gpio[7] = 1'b1;
      cycles(5);
      bus_wr(32'h0C, 32'hFFFF_FFFF, 4'hF, "clr_all2");
      gpio[7] = 1'b0;
      cycles(SS);
      bus_wr(32'h0C, 32'h80, 4'hF, "clr_vs_fall");
      bus_rd(32'h0C, IRQ ? 32'h80 : 32'd0, "set_wins");

      // Byte-lane write.
      bus_wr(32'h10, 32'd0, 4'hF, "mask_zero");
      bus_wr(32'h10, 32'hAABB_CCDD, 4'b0010, "mask_lane1");
      bus_rd(32'h10, IRQ ? 32'h0000_CC00 : 32'd0, "mask_lane1_rd");

      // Register table with steady inputs.
      gpio = 32'hA5A5_0F0F;
      cycles(5);
      vecs.push_back('{1'b1, 32'h04, 32'h1234_5678, 4'hF, 32'd0, 32'd0, "w_rise"});
      vecs.push_back('{1'b0, 32'h04, 32'd0, 4'h0, 32'h1234_5678, 32'd0, "r_rise"});
      vecs.push_back('{1'b0, 32'h24, 32'd0, 4'h0, 32'h1234_5678, 32'd0, "r_rise_alias"});
      vecs.push_back('{1'b1, 32'h08, 32'hCAFE_BABE, 4'b1001, 32'd0, 32'd0, "w_fall"});
      vecs.push_back('{1'b0, 32'h08, 32'd0, 4'h0, 32'hCA00_00BE, 32'd0, "r_fall"});
      vecs.push_back('{1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'd0, 32'd0, "w_data"});
      vecs.push_back('{1'b0, 32'h00, 32'd0, 4'h0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, "r_data"});
      vecs.push_back('{1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, 32'd0, 32'd0, "w_adr5"});
      vecs.push_back('{1'b0, 32'h14, 32'd0, 4'h0, 32'd0, 32'd0, "r_adr5"});
      vecs.push_back('{1'b0, 32'h18, 32'd0, 4'h0, 32'd0, 32'd0, "r_adr6"});
      vecs.push_back('{1'b0, 32'h1C, 32'd0, 4'h0, 32'd0, 32'd0, "r_adr7"});
      vecs.push_back('{1'b1, 32'h10, 32'hFFFF_FFFF, 4'b1100, 32'd0, 32'd0, "w_mask_hi"});
      vecs.push_back('{1'b0, 32'h10, 32'd0, 4'h0, 32'hFFFF_CC00, 32'd0, "r_mask_hi"});
      foreach (vecs[i]) begin
         if (vecs[i].we) bus_wr(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].name);
         else bus_rd(vecs[i].adr, IRQ ? vecs[i].exp_irq : vecs[i].exp_min, vecs[i].name);
      end

      // Held request: acknowledges on alternate cycles only.
      for (int i = 0; i < 3; i++) sb_q.push_back('{1'b1, 32'd0, "held_rd"});
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1C;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      cyc = 1'b0; stb = 1'b0;
      check("held_ack_count", 32'(acks), 32'd3);
      cycles(1);

      // All enables on, toggle every input.
      bus_wr(32'h04, 32'hFFFF_FFFF, 4'hF, "all_rise");
      bus_wr(32'h08, 32'hFFFF_FFFF, 4'hF, "all_fall");
      bus_wr(32'h10, 32'hFFFF_FFFF, 4'hF, "all_mask");
      gpio = ~gpio;
      cycles(5);
      gpio = ~gpio;
      cycles(5);
      check("toggle_irq", {31'd0, irq}, {31'd0, IRQ});
      bus_rd(32'h0C, IRQ ? 32'hFFFF_FFFF : 32'd0, "toggle_pending");

      // Reset asserted while an acknowledge is on the bus.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h00;
      @(posedge clk); #1;
      check("mid_ack_before", {31'd0, ack}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ack", {31'd0, ack}, 32'd0);
      check("mid_rst_dat", rdat, 32'd0);
      check("mid_rst_irq", {31'd0, irq}, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      cycles(2);
      bus_rd(32'h04, 32'd0, "post_rst_rise_en");

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
